tiny_riscv_run_ctrl: RTL and testbench
======================================

# tiny_riscv_run_ctrl

Run controller for the 8-bit tiny RISC-V core. It accepts host commands over a valid/ready port and uses them to:
- write the core's 16-entry instruction memory;
- hold and release the core's reset;
- gate the core's clock enable for free-run (RUN) or single-instruction (STEP) execution.

A watchdog ends runaway programs. The block sits between the host I/O pins and the core, and owns all core sequencing.

## Interface
Parameters:
- ADDR_WIDTH, 4, instruction-memory address width (16 entries)
- DATA_WIDTH, 8, instruction width
- WD_LIMIT, 200, maximum core-enabled cycles per RUN (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: rst_n, asynchronous, active-low; clock clk
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at the clk edge
- cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT
- cmd_addr  in  ADDR_WIDTH  LOAD address
- cmd_data  in  DATA_WIDTH  LOAD data
- imem_we  out  1  instruction-memory write strobe
- imem_waddr  out  ADDR_WIDTH  write address
- imem_wdata  out  DATA_WIDTH  write data
- core_rst_n  out  1  core reset, active-low
- core_en  out  1  core clock enable
- core_halted  in  1  core is in its HALT state (level)
- core_instr_done  in  1  one-cycle pulse when the core retires an instruction (PC advance or HALT entry)
- busy  out  1  state not IDLE
- done  out  1  one-cycle pulse when RUN/STEP completes or is aborted
- timeout  out  1  sticky; set by a watchdog expiry
- cmd_err  out  1  sticky; set when a non-ABORT command is accepted while busy
- cycle_cnt  out  8  core-enabled cycles in the current/last RUN
- state_dbg  out  3  encoded state

## Operation
States, with encodings:
- IDLE=0
- LOADW=1
- CRST=2
- RUN=3
- STEP=4
- DONE=5

Internal flag:
- core_live: cleared by reset and by LOAD; set on leaving CRST.

Per-state behaviour:
- **IDLE:** cmd_ready=1.
  - LOAD → register addr/data; imem_we=1 for one cycle; core_rst_n=0; clear core_live; go LOADW.
  - RUN → go CRST (always; RUN restarts the program from PC 0). cycle_cnt is cleared here.
  - STEP → go CRST if !core_live; else DONE if core_halted; else STEP.
  - ABORT → no-op.
- **LOADW:** one cycle; cmd_ready=0; imem_we=0; go IDLE.
- **CRST:** core_rst_n=0 for exactly 2 cycles (2-bit counter); cmd_ready=0. Then core_rst_n=1, set core_live, and go RUN or STEP per the pending command.
- **RUN:** core_en=1; cmd_ready=1. cycle_cnt increments each cycle core_en=1, saturating at 255. Exit conditions, by priority:
  1. ABORT accepted → DONE.
  2. core_halted=1 → DONE.
  3. cycle_cnt==WD_LIMIT → set timeout; go DONE.
- **STEP:** core_en=1 until core_instr_done is sampled high, then go DONE. ABORT exits to DONE. core_halted=1 also exits to DONE.
- **DONE:** core_en=0; done=1 for one cycle; cmd_ready=0; go IDLE. The core keeps its state (core_rst_n stays 1).

Command and flag rules:
- Any non-ABORT command accepted in RUN/STEP is discarded and sets cmd_err.
- timeout and cmd_err clear only on rst_n or on acceptance of a RUN.
- core_rst_n is never released during a LOAD. The memory is written only while the core is in reset.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1
  - imem_we=0, imem_waddr=0, imem_wdata=0
  - core_rst_n=0, core_en=0
  - busy=0, done=0, timeout=0, cmd_err=0
  - cycle_cnt=0, core_live=0
- All outputs are registered, except cmd_ready, busy and state_dbg (decoded from state).
- LOAD: accept at edge N; imem_we=1 during cycle N+1; next command can be accepted at edge N+2 (throughput 1 write / 2 cycles).
- RUN: accept at N; core_rst_n=0 during N+1 and N+2; core_en=1 from N+3.
- core_halted/core_instr_done are sampled registered. core_en drops one cycle after the sampling edge, so at most one extra enabled cycle reaches the core. This is harmless in HALT; in STEP the core must hold state after retiring.
- done pulses in the cycle after RUN/STEP exits. busy stays high through DONE.
- Simultaneous events in RUN, highest priority first: ABORT > halt > watchdog.
- rst_n asserted mid-RUN: everything returns to reset values asynchronously, and the core is held in reset.

## Test plan
- LOAD addr=3 data=0x59 → imem_we one cycle later with waddr=3, wdata=0x59; core_rst_n=0; cmd_ready low 1 cycle.
- RUN with core_halted rising after 7 enabled cycles → core_rst_n low 2 cycles, core_en high; done pulse; cycle_cnt=7 or 8; timeout=0.
- RUN, core_halted never set, WD_LIMIT=200 → core_en drops after cycle_cnt=200; timeout=1; done pulse; next RUN clears timeout.
- STEP after reset → CRST (2 cycles), core_en high until core_instr_done, done pulse. Second STEP → no CRST, core_en high after 1 cycle.
- During RUN, send LOAD then ABORT → LOAD dropped with cmd_err=1 and no imem_we; ABORT → DONE next cycle, done=1, core_rst_n stays 1.
- Assert rst_n during RUN → core_en=0 and core_rst_n=0 immediately; state_dbg=0; done=0.

Source files
------------

// File: rtl/tiny_riscv_run_ctrl_if.sv
// Host command port of the tiny RISC-V run controller: valid/ready handshake
// carrying an opcode plus LOAD address/data.
interface tiny_riscv_run_ctrl_if #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [AddrWidth-1:0] cmd_addr;
  logic [DataWidth-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/tiny_riscv_run_ctrl.sv
// Run controller for the 8-bit tiny RISC-V core: loads instruction memory,
// sequences core reset and gates the core clock enable for RUN/STEP with a watchdog.
module tiny_riscv_run_ctrl #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned WdLimit   = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tiny_riscv_run_ctrl_if.slave cmd_if,
  output logic                 imem_we_o,
  output logic [AddrWidth-1:0] imem_waddr_o,
  output logic [DataWidth-1:0] imem_wdata_o,
  output logic                 core_rst_n_o,
  output logic                 core_en_o,
  input  logic                 core_halted_i,
  input  logic                 core_instr_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 cmd_err_o,
  output logic [7:0]           cycle_cnt_o,
  output logic [2:0]           state_dbg_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadw = 3'd1,
    StCrst  = 3'd2,
    StRun   = 3'd3,
    StStep  = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpRun   = 2'b01;
  localparam logic [1:0] OpStep  = 2'b10;
  localparam logic [1:0] OpAbort = 2'b11;
  localparam logic [7:0] WdLimitB = 8'(WdLimit);

  state_e               state_q, state_d;
  logic                 imem_we_q, imem_we_d;
  logic [AddrWidth-1:0] waddr_q, waddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 core_rst_n_q, core_rst_n_d;
  logic                 core_en_q, core_en_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [7:0]           cycle_cnt_q, cycle_cnt_d;
  logic                 core_live_q, core_live_d;
  logic [1:0]           crst_cnt_q, crst_cnt_d;
  logic                 pend_step_q, pend_step_d;
  logic                 halted_q, instr_done_q;

  logic                 cmd_ready;
  logic                 accept;
  logic                 is_abort;
  logic [7:0]           cnt_inc;

  assign cmd_ready = (state_q == StIdle) || (state_q == StRun) || (state_q == StStep);
  assign accept    = cmd_if.cmd_valid & cmd_ready;
  assign is_abort  = (cmd_if.cmd_op == OpAbort);
  assign cnt_inc   = (cycle_cnt_q == 8'hff) ? 8'hff : cycle_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    core_rst_n_d = core_rst_n_q;
    timeout_d    = timeout_q;
    cmd_err_d    = cmd_err_q;
    cycle_cnt_d  = cycle_cnt_q;
    core_live_d  = core_live_q;
    crst_cnt_d   = crst_cnt_q;
    pend_step_d  = pend_step_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_if.cmd_op)
            OpLoad: begin
              waddr_d      = cmd_if.cmd_addr;
              wdata_d      = cmd_if.cmd_data;
              imem_we_d    = 1'b1;
              core_rst_n_d = 1'b0;
              core_live_d  = 1'b0;
              state_d      = StLoadw;
            end
            OpRun: begin
              pend_step_d = 1'b0;
              cycle_cnt_d = 8'd0;
              timeout_d   = 1'b0;
              cmd_err_d   = 1'b0;
              state_d     = StCrst;
            end
            OpStep: begin
              pend_step_d = 1'b1;
              if (!core_live_q)  state_d = StCrst;
              else if (halted_q) state_d = StDone;
              else               state_d = StStep;
            end
            OpAbort: ;
          endcase
        end
      end
      StLoadw: state_d = StIdle;
      StCrst: begin
        if (crst_cnt_q == 2'd1) begin
          core_rst_n_d = 1'b1;
          core_live_d  = 1'b1;
          state_d      = pend_step_q ? StStep : StRun;
        end else begin
          crst_cnt_d = crst_cnt_q + 2'd1;
        end
      end
      StRun: begin
        cycle_cnt_d = cnt_inc;
        // Watchdog counts the current enabled cycle, so exactly WdLimit cycles reach the core.
        if (accept && is_abort) begin
          state_d = StDone;
        end else if (halted_q) begin
          state_d = StDone;
        end else if (cnt_inc == WdLimitB) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StStep: begin
        if ((accept && is_abort) || halted_q || instr_done_q) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept && !is_abort && (state_q == StRun || state_q == StStep)) cmd_err_d = 1'b1;

    if (state_d == StCrst && state_q != StCrst) begin
      core_rst_n_d = 1'b0;
      crst_cnt_d   = 2'd0;
    end

    core_en_d = (state_d == StRun) || (state_d == StStep);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      imem_we_q    <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      cycle_cnt_q  <= 8'd0;
      core_live_q  <= 1'b0;
      crst_cnt_q   <= 2'd0;
      pend_step_q  <= 1'b0;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      core_en_q    <= core_en_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      cmd_err_q    <= cmd_err_d;
      cycle_cnt_q  <= cycle_cnt_d;
      core_live_q  <= core_live_d;
      crst_cnt_q   <= crst_cnt_d;
      pend_step_q  <= pend_step_d;
      // Core status is meaningless while it is held in reset or not clocked.
      halted_q     <= core_halted_i & core_rst_n_q;
      instr_done_q <= core_instr_done_i & core_en_q;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready;
  assign imem_we_o        = imem_we_q;
  assign imem_waddr_o     = waddr_q;
  assign imem_wdata_o     = wdata_q;
  assign core_rst_n_o     = core_rst_n_q;
  assign core_en_o        = core_en_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign timeout_o        = timeout_q;
  assign cmd_err_o        = cmd_err_q;
  assign cycle_cnt_o      = cycle_cnt_q;
  assign state_dbg_o      = state_q;

endmodule

// File: tb/tb_tiny_riscv_run_ctrl.sv
// Directed bench for tiny_riscv_run_ctrl: LOAD, RUN with halt, watchdog, command
// errors/ABORT, STEP sequencing and asynchronous reset mid-run.
module tb_tiny_riscv_run_ctrl;

  localparam logic [1:0] OpLoad  = 2'b00;
  localparam logic [1:0] OpRun   = 2'b01;
  localparam logic [1:0] OpStep  = 2'b10;
  localparam logic [1:0] OpAbort = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_we;
  logic [3:0] imem_waddr;
  logic [7:0] imem_wdata;
  logic       core_rst_n;
  logic       core_en;
  logic       core_halted;
  logic       core_instr_done;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       cmd_err;
  logic [7:0] cycle_cnt;
  logic [2:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  tiny_riscv_run_ctrl_if #(.AddrWidth(4), .DataWidth(8)) cmd_if ();

  tiny_riscv_run_ctrl #(
    .AddrWidth(4),
    .DataWidth(8),
    .WdLimit  (200)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_if           (cmd_if),
    .imem_we_o        (imem_we),
    .imem_waddr_o     (imem_waddr),
    .imem_wdata_o     (imem_wdata),
    .core_rst_n_o     (core_rst_n),
    .core_en_o        (core_en),
    .core_halted_i    (core_halted),
    .core_instr_done_i(core_instr_done),
    .busy_o           (busy),
    .done_o           (done),
    .timeout_o        (timeout),
    .cmd_err_o        (cmd_err),
    .cycle_cnt_o      (cycle_cnt),
    .state_dbg_o      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
    cmd_if.cmd_op    = op;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_data  = data;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_addr  = 4'd0;
    cmd_if.cmd_data  = 8'd0;
    core_halted      = 1'b0;
    core_instr_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_waddr", imem_waddr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_core_en", core_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    // LOAD addr=3 data=0x59
    send(OpLoad, 4'd3, 8'h59);
    check("load_we", imem_we, 1);
    check("load_waddr", imem_waddr, 3);
    check("load_wdata", imem_wdata, 8'h59);
    check("load_core_rst_n", core_rst_n, 0);
    check("load_ready", cmd_if.cmd_ready, 0);
    check("load_state", state_dbg, 1);
    tick();
    check("load_we_off", imem_we, 0);
    check("load_ready_back", cmd_if.cmd_ready, 1);
    check("load_state_idle", state_dbg, 0);

    // RUN, core halts during its 7th enabled cycle
    send(OpRun, 4'd0, 8'd0);
    check("run1_crst_a", core_rst_n, 0);
    check("run1_state_crst", state_dbg, 2);
    check("run1_ready_crst", cmd_if.cmd_ready, 0);
    tick();
    check("run1_crst_b", core_rst_n, 0);
    check("run1_en_crst", core_en, 0);
    tick();
    check("run1_rel", core_rst_n, 1);
    check("run1_en", core_en, 1);
    check("run1_state_run", state_dbg, 3);
    check("run1_cnt0", cycle_cnt, 0);
    repeat (6) tick();
    check("run1_cnt6", cycle_cnt, 6);
    core_halted = 1'b1;
    tick();
    check("run1_still_run", state_dbg, 3);
    check("run1_cnt7", cycle_cnt, 7);
    tick();
    check("run1_state_done", state_dbg, 5);
    check("run1_done", done, 1);
    check("run1_en_off", core_en, 0);
    check("run1_cnt8", cycle_cnt, 8);
    check("run1_core_rst_n", core_rst_n, 1);
    check("run1_timeout", timeout, 0);
    check("run1_busy_done", busy, 1);
    check("run1_ready_done", cmd_if.cmd_ready, 0);
    tick();
    check("run1_done_off", done, 0);
    check("run1_busy_off", busy, 0);
    core_halted = 1'b0;
    tick();

    // RUN without halt: watchdog after 200 enabled cycles
    send(OpRun, 4'd0, 8'd0);
    tick();
    tick();
    check("wd_en", core_en, 1);
    repeat (199) tick();
    check("wd_en_199", core_en, 1);
    check("wd_cnt_199", cycle_cnt, 199);
    check("wd_to_pre", timeout, 0);
    tick();
    check("wd_en_off", core_en, 0);
    check("wd_cnt_200", cycle_cnt, 200);
    check("wd_timeout", timeout, 1);
    check("wd_done", done, 1);
    tick();
    check("wd_idle", state_dbg, 0);
    check("wd_timeout_sticky", timeout, 1);

    // Next RUN clears timeout; LOAD while running is an error; ABORT ends it
    send(OpRun, 4'd0, 8'd0);
    check("run3_to_clr", timeout, 0);
    check("run3_cnt_clr", cycle_cnt, 0);
    tick();
    tick();
    check("run3_state", state_dbg, 3);
    send(OpLoad, 4'd5, 8'hAA);
    check("run3_cmd_err", cmd_err, 1);
    check("run3_no_we", imem_we, 0);
    check("run3_waddr_kept", imem_waddr, 3);
    check("run3_still_run", state_dbg, 3);
    send(OpAbort, 4'd0, 8'd0);
    check("abort_state", state_dbg, 5);
    check("abort_done", done, 1);
    check("abort_core_rst_n", core_rst_n, 1);
    check("abort_en_off", core_en, 0);
    tick();
    check("abort_idle", state_dbg, 0);
    check("abort_cmd_err_sticky", cmd_err, 1);

    // ABORT in IDLE is a no-op
    send(OpAbort, 4'd0, 8'd0);
    check("idle_abort_state", state_dbg, 0);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // STEP with a live, halted core finishes at once
    core_halted = 1'b1;
    tick();
    send(OpStep, 4'd0, 8'd0);
    check("step_halt_state", state_dbg, 5);
    check("step_halt_en", core_en, 0);
    check("step_halt_done", done, 1);
    check("step_halt_cmd_err", cmd_err, 1);
    tick();
    core_halted = 1'b0;
    tick();

    // Asynchronous reset mid-RUN
    send(OpRun, 4'd0, 8'd0);
    tick();
    tick();
    check("ar_en_pre", core_en, 1);
    rst_n = 1'b0;
    #2;
    check("ar_en", core_en, 0);
    check("ar_core_rst_n", core_rst_n, 0);
    check("ar_state", state_dbg, 0);
    check("ar_done", done, 0);
    check("ar_cnt", cycle_cnt, 0);
    check("ar_cmd_err", cmd_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // STEP after reset goes through CRST
    send(OpStep, 4'd0, 8'd0);
    check("st1_crst_a", state_dbg, 2);
    check("st1_core_rst_n_a", core_rst_n, 0);
    tick();
    check("st1_crst_b", state_dbg, 2);
    tick();
    check("st1_state", state_dbg, 4);
    check("st1_en", core_en, 1);
    check("st1_core_rst_n", core_rst_n, 1);
    tick();
    check("st1_en_wait", core_en, 1);
    core_instr_done = 1'b1;
    tick();
    core_instr_done = 1'b0;
    check("st1_en_extra", core_en, 1);
    tick();
    check("st1_done_state", state_dbg, 5);
    check("st1_done", done, 1);
    check("st1_en_off", core_en, 0);
    tick();
    check("st1_idle", state_dbg, 0);

    // Second STEP skips CRST
    send(OpStep, 4'd0, 8'd0);
    check("st2_state", state_dbg, 4);
    check("st2_en", core_en, 1);
    check("st2_core_rst_n", core_rst_n, 1);
    core_instr_done = 1'b1;
    tick();
    core_instr_done = 1'b0;
    tick();
    check("st2_done", done, 1);
    check("st2_en_off", core_en, 0);
    tick();
    check("st2_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
